wire_pipe: RTL and testbench

WIRE_PIPE -- requirements
Module: wire_pipe

---
 rtl/wire_pipe.sv | 128 ++++++++++++
 tb/tb_wire_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wire_pipe.sv
// Valid-tagged delay line with stall/flush control, occupancy tracking,
// a fill-state FSM and a saturating count of data changes between accepted beats.
module wire_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic             a_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] B,
    output logic             b_valid,
    output logic [WIDTH-1:0] C,
    output logic             c_valid,
    output logic [4:0]       occupancy,
    output logic [1:0]       state,
    output logic [15:0]      chg_count
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    logic [DEPTH-1:0] vld_p;
    logic [WIDTH-1:0] dat_p [DEPTH];
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] dat_d [DEPTH];

    logic [4:0]       occ_q;
    logic [4:0]       occ_d;
    state_t           state_q;
    state_t           state_d;

    logic [15:0]      chg_q;
    logic [WIDTH-1:0] last_q;
    logic             first_q;
    logic             accept;

    function automatic logic [4:0] count_valid(input logic [DEPTH-1:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign accept = a_valid & ~stall & ~flush;

    // Next-stage contents: flush wins, stall holds, otherwise shift one stage
    always_comb begin
        vld_d = vld_p;
        dat_d = dat_p;
        if (flush) begin
            vld_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_d[k] = '0;
            end
        end else if (!stall) begin
            vld_d[0] = a_valid;
            dat_d[0] = a_valid ? A : '0;
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_p[k-1];
                dat_d[k] = dat_p[k-1];
            end
        end
    end

    // Occupancy and fill state are registered from the next-stage valid bits
    always_comb begin
        occ_d   = count_valid(vld_d);
        state_d = FILLING;
        if (occ_d == 5'd0) begin
            state_d = EMPTY;
        end else if (occ_d == 5'(DEPTH)) begin
            state_d = FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_p[k] <= '0;
            end
            occ_q   <= '0;
            state_q <= EMPTY;
        end else begin
            vld_p   <= vld_d;
            dat_p   <= dat_d;
            occ_q   <= occ_d;
            state_q <= state_d;
        end
    end

    // Change counter survives flush; the first beat after reset only seeds last_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q   <= '0;
            last_q  <= '0;
            first_q <= 1'b1;
        end else if (accept) begin
            last_q <= A;
            if (first_q) begin
                first_q <= 1'b0;
            end else if (A != last_q) begin
                chg_q <= sat_inc(chg_q);
            end
        end
    end

    assign B         = dat_p[0];
    assign b_valid   = vld_p[0];
    assign C         = dat_p[DEPTH-1];
    assign c_valid   = vld_p[DEPTH-1];
    assign occupancy = occ_q;
    assign state     = state_q;
    assign chg_count = chg_q;

endmodule

// File: tb/tb_wire_pipe.sv
// Bench for wire_pipe (WIDTH=1, DEPTH=4): directed vector table, reset and
// saturation sequences, and random traffic against a queue-based reference.
module tb_wire_pipe;

    localparam int WIDTH = 1;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic             a_valid = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] B;
    logic             b_valid;
    logic [WIDTH-1:0] C;
    logic             c_valid;
    logic [4:0]       occupancy;
    logic [1:0]       state;
    logic [15:0]      chg_count;

    int errors = 0;
    int checks = 0;

    wire_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .a_valid(a_valid), .stall(stall),
        .flush(flush), .B(B), .b_valid(b_valid), .C(C), .c_valid(c_valid),
        .occupancy(occupancy), .state(state), .chg_count(chg_count)
    );

    always #10 clk = ~clk;

    // Reference model: a queue holding the beats in the pipe, newest first
    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
    } beat_t;

    beat_t            mq[$];
    logic             m_first;
    logic [WIDTH-1:0] m_last;
    int               m_cnt;

    typedef struct {
        bit               rst_before;
        logic [WIDTH-1:0] a;
        logic             av, st, fl;
        logic [WIDTH-1:0] eb;
        logic             ebv;
        logic [WIDTH-1:0] ec;
        logic             ecv;
        logic [4:0]       eocc;
        logic [1:0]       est;
        logic [15:0]      echg;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] pack(input logic [WIDTH-1:0] b, input logic bv,
                                         input logic [WIDTH-1:0] c, input logic cv,
                                         input logic [4:0] occ, input logic [1:0] st,
                                         input logic [15:0] chg);
        return 64'({b, bv, c, cv, occ, st, chg});
    endfunction

    function automatic logic [63:0] dut_vec();
        return pack(B, b_valid, C, c_valid, occupancy, state, chg_count);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        beat_t z;
        z.v = 1'b0;
        z.d = '0;
        mq = {};
        for (int i = 0; i < DEPTH; i++) mq.push_back(z);
        m_first = 1'b1;
        m_last  = '0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic [WIDTH-1:0] a, input logic av,
                              input logic st, input logic fl);
        beat_t nb;
        if (fl) begin
            model_reset_stages();
        end else if (!st) begin
            nb.v = av;
            nb.d = av ? a : '0;
            mq.push_front(nb);
            void'(mq.pop_back());
            if (av) begin
                if (m_first) m_first = 1'b0;
                else if (a != m_last && m_cnt < 65535) m_cnt++;
                m_last = a;
            end
        end
    endtask

    task automatic model_reset_stages();
        for (int i = 0; i < DEPTH; i++) begin
            mq[i].v = 1'b0;
            mq[i].d = '0;
        end
    endtask

    function automatic logic [63:0] model_vec();
        int occ = 0;
        logic [1:0] st;
        foreach (mq[i]) if (mq[i].v) occ++;
        st = (occ == 0) ? 2'd0 : (occ == DEPTH) ? 2'd2 : 2'd1;
        return pack(mq[0].d, mq[0].v, mq[DEPTH-1].d, mq[DEPTH-1].v, 5'(occ), st, 16'(m_cnt));
    endfunction

    task automatic step(input logic [WIDTH-1:0] a, input logic av,
                        input logic st, input logic fl);
        A = a;
        a_valid = av;
        stall = st;
        flush = fl;
        model_edge(a, av, st, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        A = '0;
        a_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic add(input bit r, input logic a, input logic av, input logic st,
                       input logic fl, input logic eb, input logic ebv, input logic ec,
                       input logic ecv, input int eocc, input int est, input int echg);
        vec_t v;
        v.rst_before = r;
        v.a = a; v.av = av; v.st = st; v.fl = fl;
        v.eb = eb; v.ebv = ebv; v.ec = ec; v.ecv = ecv;
        v.eocc = 5'(eocc); v.est = 2'(est); v.echg = 16'(echg);
        vecs.push_back(v);
    endtask

    initial begin
        // Toggle fill, stall with A changing, then flush together with stall
        add(1, 0, 1, 0, 0,  0, 1, 0, 0,  1, 1, 0);
        add(0, 1, 1, 0, 0,  1, 1, 0, 0,  2, 1, 1);
        add(0, 0, 1, 0, 0,  0, 1, 0, 0,  3, 1, 2);
        add(0, 1, 1, 0, 0,  1, 1, 0, 1,  4, 2, 3);
        add(0, 0, 1, 1, 0,  1, 1, 0, 1,  4, 2, 3);
        add(0, 1, 1, 1, 0,  1, 1, 0, 1,  4, 2, 3);
        add(0, 0, 1, 1, 0,  1, 1, 0, 1,  4, 2, 3);
        add(0, 0, 1, 0, 0,  0, 1, 1, 1,  4, 2, 4);
        add(0, 1, 1, 1, 1,  0, 0, 0, 0,  0, 0, 4);
        // Bubbles from a fresh reset
        add(1, 1, 1, 0, 0,  1, 1, 0, 0,  1, 1, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0);
        add(0, 1, 1, 0, 0,  1, 1, 0, 0,  2, 1, 0);
        add(0, 1, 0, 0, 0,  0, 0, 1, 1,  2, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1,  1, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0);

        #5;
        check("reset_state", dut_vec(), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            step(vecs[i].a, vecs[i].av, vecs[i].st, vecs[i].fl);
            check($sformatf("vec%0d", i), dut_vec(),
                  pack(vecs[i].eb, vecs[i].ebv, vecs[i].ec, vecs[i].ecv,
                       vecs[i].eocc, vecs[i].est, vecs[i].echg));
        end

        // Asynchronous reset between edges while filling
        do_reset();
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("pre_async_chg", 64'(chg_count), 64'd2);
        #4 rst_n = 1'b0;
        #1 check("async_reset", dut_vec(), 64'd0);
        #2;
        rst_n = 1'b1;
        model_reset();
        step(0, 1, 0, 0);
        check("post_rst_first", dut_vec(), pack(0, 1, 0, 0, 5'd1, 2'd1, 16'd0));
        step(1, 1, 0, 0);
        check("post_rst_second", dut_vec(), pack(1, 1, 0, 0, 5'd2, 2'd1, 16'd1));

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(WIDTH'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
            check("random", dut_vec(), model_vec());
        end

        // Saturation: alternating beats, each after the first counts once
        do_reset();
        for (int i = 0; i < 65535; i++) step(WIDTH'(i & 1), 1'b1, 1'b0, 1'b0);
        check("chg_before_sat", 64'(chg_count), 64'h0000_FFFE);
        for (int i = 65535; i < 65538; i++) step(WIDTH'(i & 1), 1'b1, 1'b0, 1'b0);
        check("chg_saturated", 64'(chg_count), 64'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
